// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI pins plus byte-level user handshake of spi_slave
// Revision     : 1.0
// ============================================================================
interface spi_slave_if;
    logic       sck;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_q;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] count;
    logic [7:0] tx_d;
    logic       tx_req;
    logic       active;

    modport slave (
        input  sck, ss_n, mosi, tx_d,
        output miso, miso_oe, rx_q, rx_valid, rx_first, count, tx_req, active
    );

    modport master (
        output sck, ss_n, mosi, tx_d,
        input  miso, miso_oe, rx_q, rx_valid, rx_first, count, tx_req, active
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// spi_slave : oversampled SPI mode-0 responder, byte strobes and reply serialiser
// Revision  : 1.0
// ============================================================================
module spi_slave #(
    parameter int SYNC = 2
) (
    input  logic        clock,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_ACTIVE    = 2'd2
    } state_t;

    localparam logic [1:0] c_SETTLE = 2'(SYNC);

    logic [SYNC-1:0] r_sck_sync;
    logic [SYNC-1:0] r_ss_sync;
    logic [SYNC-1:0] r_mosi_sync;
    logic            r_sck_d;
    logic            r_ss_d;

    state_t          r_state;
    logic [1:0]      r_settle;
    logic [2:0]      r_bit;
    logic [6:0]      r_rx_sr;
    logic [6:0]      r_tx_sr;
    logic            r_first;
    logic            r_reload;
    logic            r_miso;
    logic            r_miso_oe;
    logic [7:0]      r_rx_q;
    logic            r_rx_valid;
    logic            r_rx_first;
    logic [7:0]      r_count;
    logic            r_tx_req;
    logic            r_active;

    logic w_sck_s, w_ss_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

    assign w_sck_s    = r_sck_sync[SYNC-1];
    assign w_ss_s     = r_ss_sync[SYNC-1];
    assign w_mosi_s   = r_mosi_sync[SYNC-1];
    assign w_sck_rise =  w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s &  r_sck_d;
    assign w_ss_rise  =  w_ss_s  & ~r_ss_d;
    assign w_ss_fall  = ~w_ss_s  &  r_ss_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC-2:0], bus.sck};
            r_ss_sync   <= {r_ss_sync[SYNC-2:0], bus.ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], bus.mosi};
            r_sck_d     <= w_sck_s;
            r_ss_d      <= w_ss_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_WAIT_IDLE;
            r_settle   <= 2'd0;
            r_bit      <= 3'd0;
            r_rx_sr    <= 7'd0;
            r_tx_sr    <= 7'd0;
            r_first    <= 1'b0;
            r_reload   <= 1'b0;
            r_miso     <= 1'b1;
            r_miso_oe  <= 1'b0;
            r_rx_q     <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_count    <= 8'h00;
            r_tx_req   <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            case (r_state)
                S_WAIT_IDLE: begin
                    // The select chain resets to "deselected", so demand a
                    // run of SYNC+1 high samples: the reset preset has then
                    // been flushed and a held-low select cannot sneak through.
                    if (!w_ss_s) begin
                        r_settle <= 2'd0;
                    end else if (r_settle == c_SETTLE) begin
                        r_settle <= 2'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_settle <= r_settle + 2'd1;
                    end
                end
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= S_ACTIVE;
                        r_bit     <= 3'd0;
                        r_active  <= 1'b1;
                        r_miso_oe <= 1'b1;
                        r_tx_sr   <= bus.tx_d[6:0];
                        r_miso    <= bus.tx_d[7];
                        r_tx_req  <= 1'b1;
                        r_first   <= 1'b1;
                        r_reload  <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    // Deselect takes priority over any coincident sck edge.
                    if (w_ss_rise) begin
                        r_state   <= S_IDLE;
                        r_active  <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_miso    <= 1'b1;
                        r_bit     <= 3'd0;
                        r_reload  <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx_sr <= {r_rx_sr[5:0], w_mosi_s};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rx_q     <= {r_rx_sr, w_mosi_s};
                            r_rx_valid <= 1'b1;
                            r_rx_first <= r_first;
                            if (r_first)
                                r_count <= 8'h00;
                            else if (r_count != 8'hFF)
                                r_count <= r_count + 8'd1;
                            r_first  <= 1'b0;
                            r_reload <= 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        if (r_reload) begin
                            r_tx_sr  <= bus.tx_d[6:0];
                            r_miso   <= bus.tx_d[7];
                            r_tx_req <= 1'b1;
                            r_reload <= 1'b0;
                        end else begin
                            r_tx_sr <= {r_tx_sr[5:0], 1'b1};
                            r_miso  <= r_tx_sr[6];
                        end
                    end
                end
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

    assign bus.miso     = r_miso;
    assign bus.miso_oe  = r_miso_oe;
    assign bus.rx_q     = r_rx_q;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_first = r_rx_first;
    assign bus.count    = r_count;
    assign bus.tx_req   = r_tx_req;
    assign bus.active   = r_active;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_slave : randomized SPI master against a byte-level reference model
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int SYNC = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_slave_if bus();
    spi_slave #(.SYNC(SYNC)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    byte unsigned tx_src   [0:511];
    byte unsigned mosi_src [0:511];
    byte unsigned miso_rx  [0:511];
    int tx_n    = 1;
    int tx_base = 0;
    int tx_idx;

    byte unsigned obs_data  [0:1023];
    bit           obs_first [0:1023];
    byte unsigned obs_count [0:1023];
    int           obs_cyc   [0:1023];
    int obs_cnt      = 0;
    int tx_req_total = 0;
    int active_cnt   = 0;
    int dbl_pulse    = 0;
    int overlap      = 0;
    int rise_cyc     = 0;

    // Each tx_req consumes one reply byte; past the end the last one repeats.
    assign tx_idx   = ((tx_req_total - tx_base) >= tx_n) ? tx_n - 1 : tx_req_total - tx_base;
    assign bus.tx_d = tx_src[tx_idx];

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin : monitor
        bit prev_rv = 1'b0;
        bit prev_tr = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.rx_valid) begin
                if (obs_cnt < 1024) begin
                    obs_data[obs_cnt]  = bus.rx_q;
                    obs_first[obs_cnt] = bus.rx_first;
                    obs_count[obs_cnt] = bus.count;
                    obs_cyc[obs_cnt]   = cyc;
                end
                obs_cnt++;
            end
            if (bus.tx_req) tx_req_total++;
            if (bus.rx_valid && bus.tx_req) overlap++;
            if ((bus.rx_valid && prev_rv) || (bus.tx_req && prev_tr)) dbl_pulse++;
            prev_rv = bus.rx_valid;
            prev_tr = bus.tx_req;
            if (bus.active) active_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input bit b, input int half, output bit m);
        bus.mosi = b;
        wait_clks(half);
        m = bus.miso;
        bus.sck  = 1'b1;
        rise_cyc = cyc;
        wait_clks(half);
    endtask

    // Master side of one frame: n bytes of mosi_src out, replies into miso_rx.
    task automatic run_frame(input int n, input int half, input bit simul_end);
        byte unsigned b, m;
        bit mb;
        tx_base = tx_req_total;
        bus.ss_n = 1'b0;
        wait_clks(half);
        chk("tx_req_at_select", tx_req_total - tx_base, 1);
        chk("miso_oe_on", bus.miso_oe, 1'b1);
        for (int k = 0; k < n; k++) begin
            b = mosi_src[k];
            m = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i], half, mb);
                m = {m[6:0], mb};
                if (simul_end && k == n - 1 && i == 0) bus.ss_n = 1'b1;
                bus.sck = 1'b0;
            end
            miso_rx[k] = m;
        end
        if (simul_end) begin
            wait_clks(SYNC + 1);
            chk("simul_miso_oe", bus.miso_oe, 1'b0);
            chk("simul_miso", bus.miso, 1'b1);
        end
        wait_clks(half);
        bus.ss_n = 1'b1;
        wait_clks(2 * half);
        chk("tx_req_per_frame", tx_req_total - tx_base, simul_end ? n : n + 1);
        chk("active_off", bus.active, 1'b0);
    endtask

    task automatic check_frame(input int n, input int ob);
        chk("rx_n", obs_cnt - ob, n);
        for (int k = 0; k < n; k++) begin
            if (ob + k < 1024) begin
                chk("rx_q", obs_data[ob + k], mosi_src[k]);
                chk("rx_first", obs_first[ob + k], (k == 0));
                chk("count", obs_count[ob + k], (k > 255) ? 255 : k);
            end
            chk("miso_byte", miso_rx[k], tx_src[k]);
        end
    endtask

    initial begin : main
        int ob, n, half;
        byte unsigned a5;
        bit mb;
        bus.sck  = 1'b0;
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;

        // Reset values, with the master already mid-frame.
        wait_clks(3);
        chk("rst_miso", bus.miso, 1'b1);
        chk("rst_miso_oe", bus.miso_oe, 1'b0);
        chk("rst_rx_q", bus.rx_q, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_rx_first", bus.rx_first, 1'b0);
        chk("rst_tx_req", bus.tx_req, 1'b0);
        chk("rst_active", bus.active, 1'b0);
        chk("rst_count", bus.count, 8'h00);
        reset = 1'b1;

        ob = obs_cnt;
        for (int i = 0; i < 16; i++) begin
            bus.mosi = i[0];
            wait_clks(4);
            bus.sck = 1'b1;
            wait_clks(4);
            bus.sck = 1'b0;
        end
        wait_clks(8);
        chk("midframe_rx_valid", obs_cnt - ob, 0);
        chk("midframe_active", active_cnt, 0);
        bus.ss_n = 1'b1;
        wait_clks(12);

        // Single byte: reply A5h, receive 3Ch.
        tx_src[0] = 8'hA5; tx_src[1] = 8'hA5; tx_n = 2;
        mosi_src[0] = 8'h3C;
        ob = obs_cnt;
        run_frame(1, 4, 1'b0);
        check_frame(1, ob);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            mb = miso_rx[0][7 - i];
            chk("miso_bit", mb, a5[7 - i]);
        end
        if (ob < 1024) chk("rx_latency", obs_cyc[ob] - rise_cyc, SYNC + 1);

        // Three bytes with reply updated on every tx_req.
        tx_src[0] = 8'h11; tx_src[1] = 8'h22; tx_src[2] = 8'h33; tx_src[3] = 8'h44; tx_n = 4;
        mosi_src[0] = 8'h01; mosi_src[1] = 8'h02; mosi_src[2] = 8'h03;
        ob = obs_cnt;
        run_frame(3, 4, 1'b0);
        check_frame(3, ob);

        // Abort after five bits.
        tx_src[0] = 8'h5A; tx_n = 1;
        tx_base = tx_req_total;
        ob = obs_cnt;
        bus.ss_n = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 4, mb);
            bus.sck = 1'b0;
        end
        wait_clks(4);
        bus.ss_n = 1'b1;
        wait_clks(8);
        chk("abort_rx_valid", obs_cnt - ob, 0);
        chk("abort_miso_oe", bus.miso_oe, 1'b0);
        chk("abort_miso", bus.miso, 1'b1);
        chk("abort_rx_q_hold", bus.rx_q, 8'h03);
        chk("abort_count_hold", bus.count, 8'h02);
        tx_src[0] = 8'hE7; tx_src[1] = 8'h18; tx_n = 2;
        mosi_src[0] = 8'h81;
        ob = obs_cnt;
        run_frame(1, 4, 1'b0);
        check_frame(1, ob);

        // Long frame: count saturates at FFh.
        n = 300;
        for (int k = 0; k <= n; k++) tx_src[k] = 8'($urandom);
        for (int k = 0; k < n; k++) mosi_src[k] = 8'($urandom);
        tx_n = n + 1;
        ob = obs_cnt;
        run_frame(n, 4, 1'b0);
        check_frame(n, ob);

        // Deselect coincident with the final sck fall.
        tx_src[0] = 8'h96; tx_src[1] = 8'h69; tx_n = 2;
        mosi_src[0] = 8'hC3;
        ob = obs_cnt;
        run_frame(1, 4, 1'b1);
        check_frame(1, ob);

        // Random frames at random sck rates.
        for (int f = 0; f < 6; f++) begin
            n    = $urandom_range(1, 5);
            half = $urandom_range(4, 7);
            for (int k = 0; k <= n; k++) tx_src[k] = 8'($urandom);
            for (int k = 0; k < n; k++) mosi_src[k] = 8'($urandom);
            tx_n = n + 1;
            ob = obs_cnt;
            run_frame(n, half, 1'b0);
            check_frame(n, ob);
        end

        chk("pulse_width", dbl_pulse, 0);
        chk("pulse_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 responder: the target side of the same SPI link our host-side master drives; lets an external controller (MCU/ARM) talk to the core for config, keyboard/joystick injection and disk-image data.
- Oversamples `sck`/`ss_n`/`mosi` in the system clock domain and deserialises bytes MSB first.
- Serialises a reply byte on `miso` in the same frame.
- Presents per-byte strobes, a first-byte flag and a byte counter to the command decoder above it.

Parameters:
- SYNC, 2: synchroniser depth on `sck`, `ss_n` and `mosi`; legal values 2..3.

Ports:
- clock  in  1  system clock; must be ≥ 8× the `sck` frequency.
- reset  in  1  asynchronous, active-low.
- sck  in  1  SPI clock from the external master; idles low (mode 0).
- ss_n  in  1  SPI select, active-low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the top-level tri-state buffer.
- rx_q  out  8  last complete received byte.
- rx_valid  out  1  one-clock pulse: `rx_q` updated.
- rx_first  out  1  set with `rx_valid` when the byte is the first of the frame; held until the next `rx_valid`.
- count  out  8  index of the byte in `rx_q` within the frame; 0 = first byte; saturates at 255.
- tx_d  in  8  next reply byte; sampled on the `tx_req` cycle.
- tx_req  out  1  one-clock pulse: `tx_d` captured; the user may present the following byte.
- active  out  1  frame in progress (synchronised select asserted and armed).

Behaviour:
- Reset values:
  - `miso` = 1, `miso_oe` = 0, `rx_q` = 00h.
  - `rx_valid`, `rx_first`, `tx_req`, `active` = 0, `count` = 0.
  - Internal bit counter = 0.
  - State = WAIT_IDLE.
  - Synchroniser flops reset to `sck` = 0, `ss_n` = 1.
- Synchronisation and edge detection:
  - SYNC-deep flop chains on the three inputs, plus one delay flop on the `sck` and `ss_n` chains.
  - `rise` = s & !d; `fall` = !s & d.
  - All actions below occur on the clock edge where the detected edge is seen; the outputs are registered.
  - Latency from an input pin edge to the output change = SYNC+1 clocks.
- States:
  - WAIT_IDLE:
    - Entered from reset.
    - Ignores all activity until synchronised `ss_n` = 1, then goes to IDLE.
    - A reset released mid-frame therefore never yields a partial byte.
  - IDLE, on `ss_n` fall:
    - Go to ACTIVE with bit counter = 0, `active` = 1, `miso_oe` = 1.
    - Load the `tx_d` shift register; `miso` = `tx_d`[7]; pulse `tx_req`.
    - Set internal flag `first` = 1.
  - ACTIVE, `sck` rise:
    - Shift `mosi` into the rx shift register LSB (MSB first).
    - Increment the bit counter (mod 8).
    - When the counter wraps 7→0:
      - `rx_q` = the assembled byte; `rx_valid` pulses; `rx_first` = `first`.
      - `count` = 0 if `first`, else `count`+1 saturating at 255.
      - Clear `first`; set internal `reload` = 1.
  - ACTIVE, `sck` fall:
    - If `reload`: load `tx_d` into the tx shift register, `miso` = `tx_d`[7], pulse `tx_req`, clear `reload`.
    - Otherwise: shift the tx register left; `miso` = next bit.
    - Shift-in is 1s.
  - ACTIVE, `ss_n` rise (any bit position):
    - Go to IDLE; `active` = 0, `miso_oe` = 0, `miso` = 1.
    - Discard the partial byte, with no `rx_valid`.
    - `rx_q`, `rx_first` and `count` hold their values.
    - Bit counter = 0; `reload` cleared.
- Simultaneous events:
  - `ss_n` rise seen in the same clock as an `sck` edge: the `ss_n` rise wins and the `sck` edge is ignored.
  - `ss_n` fall with `sck` = 1 (mode violation): frame starts; the first `sck` fall only shifts.
- `rx_valid` and `tx_req` are never high for more than one clock. They are never high in the same clock, because they are caused by different `sck` edges.
- The user must drive `tx_d` valid before the next `sck` fall following `rx_valid`. With no update, the previously presented byte is resent.
- Nothing is buffered beyond one byte; an overrun is impossible by construction (one byte per 8 `sck`).

Test Plan:
- Reset released with `ss_n` = 0 and `sck` toggling 16 times → `rx_valid` never pulses and `active` = 0. After `ss_n` goes 1 then 0, a normal frame is accepted.
- `tx_d` = A5h, `ss_n` low, master sends 3Ch → `tx_req` pulses at `ss_n` fall; `miso` bits = 1,0,1,0,0,1,0,1. `rx_q` = 3Ch with `rx_valid` one clock, `rx_first` = 1, `count` = 0, pulse SYNC+1 clocks after the 8th `sck` rise.
- Three-byte frame 01h,02h,03h with `tx_d` updated on each `tx_req` to 11h,22h,33h → master reads 11h,22h,33h. `rx_first` sequence = 1,0,0; `count` = 0,1,2.
- `ss_n` raised after 5 bits → no `rx_valid`; `miso_oe` = 0, `miso` = 1. The next frame's first byte 81h is received correctly with `rx_first` = 1.
- 300-byte frame → `count` saturates at FFh from byte 255 onwards; every byte still strobes `rx_valid`.
- `sck` at `clock`/8 with `ss_n` rising in the same clock as the last `sck` fall → `ss_n` wins: no `tx_req`, and IDLE outputs (`miso_oe` = 0, `miso` = 1) on the next cycle.
